// File: rtl/core_pkg.sv
// Shared definitions for the RV64I+Zba core: datapath width, result-source
// encoding and load funct3 codes.
package core_pkg;

  localparam int unsigned XLEN = 64;

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_LOAD = 2'b01,
    RES_PC4  = 2'b10
  } result_src_e;

  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b010;
  localparam logic [2:0] LD_LD  = 3'b011;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;
  localparam logic [2:0] LD_LWU = 3'b110;

endpackage

// File: rtl/load_extend.sv
// Aligns a raw memory doubleword by byte offset and sign/zero-extends it
// according to the load funct3.
module load_extend
  import core_pkg::LD_LB, core_pkg::LD_LH, core_pkg::LD_LW, core_pkg::LD_LD,
         core_pkg::LD_LBU, core_pkg::LD_LHU, core_pkg::LD_LWU;
#(
  parameter int unsigned XLEN = core_pkg::XLEN
) (
  input  logic [XLEN-1:0] read_data,
  input  logic [2:0]      off,
  input  logic [2:0]      load_type,
  output logic [XLEN-1:0] ext_c
);

  logic [XLEN-1:0] sh;

  // Bytes shifted out past the top are refilled with zeros before extension.
  always_comb begin
    sh    = read_data >> {off, 3'b000};
    ext_c = '0;
    case (load_type)
      LD_LB:   ext_c = {{(XLEN-8){sh[7]}},   sh[7:0]};
      LD_LH:   ext_c = {{(XLEN-16){sh[15]}}, sh[15:0]};
      LD_LW:   ext_c = {{(XLEN-32){sh[31]}}, sh[31:0]};
      LD_LD:   ext_c = sh;
      LD_LBU:  ext_c = {{(XLEN-8){1'b0}},    sh[7:0]};
      LD_LHU:  ext_c = {{(XLEN-16){1'b0}},   sh[15:0]};
      LD_LWU:  ext_c = {{(XLEN-32){1'b0}},   sh[31:0]};
      default: ext_c = '0;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register and writeback: result selection, register-file
// write port, W-stage forwarding bus and retired-instruction counter.
module writeback_stage
  import core_pkg::RES_ALU, core_pkg::RES_LOAD, core_pkg::RES_PC4;
#(
  parameter int unsigned XLEN  = core_pkg::XLEN,
  parameter int unsigned CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_W,
  input  logic             flush_W,
  input  logic             valid_M,
  input  logic             RegWrite_M,
  input  logic [1:0]       ResultSrc_M,
  input  logic [2:0]       LoadType_M,
  input  logic [4:0]       Rd_M,
  input  logic [XLEN-1:0]  ALUResult_M,
  input  logic [XLEN-1:0]  ReadData_M,
  input  logic [XLEN-1:0]  PCPlus4_M,
  output logic [4:0]       A3,
  output logic [XLEN-1:0]  WD3,
  output logic             WE3,
  output logic [4:0]       Rd_W,
  output logic             RegWrite_W,
  output logic [XLEN-1:0]  Result_W,
  output logic [CNT_W-1:0] instret
);

  logic             valid_q,      valid_d;
  logic             reg_write_q,  reg_write_d;
  logic [1:0]       result_src_q, result_src_d;
  logic [2:0]       load_type_q,  load_type_d;
  logic [4:0]       rd_q,         rd_d;
  logic [XLEN-1:0]  alu_q,        alu_d;
  logic [XLEN-1:0]  rdata_q,      rdata_d;
  logic [XLEN-1:0]  pc4_q,        pc4_d;
  logic [CNT_W-1:0] instret_q,    instret_d;

  logic [XLEN-1:0]  load_val_c;
  logic [XLEN-1:0]  result_c;
  logic             we_c;

  // Flush beats stall; an instruction retires only when it actually leaves W.
  always_comb begin
    valid_d      = valid_q;
    reg_write_d  = reg_write_q;
    result_src_d = result_src_q;
    load_type_d  = load_type_q;
    rd_d         = rd_q;
    alu_d        = alu_q;
    rdata_d      = rdata_q;
    pc4_d        = pc4_q;
    instret_d    = instret_q;
    if (flush_W) begin
      valid_d = 1'b0;
    end else if (!stall_W) begin
      valid_d      = valid_M;
      reg_write_d  = RegWrite_M;
      result_src_d = ResultSrc_M;
      load_type_d  = LoadType_M;
      rd_d         = Rd_M;
      alu_d        = ALUResult_M;
      rdata_d      = ReadData_M;
      pc4_d        = PCPlus4_M;
    end
    if (valid_q && !stall_W && !flush_W) begin
      instret_d = instret_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      result_src_q <= 2'b00;
      load_type_q  <= 3'b000;
      rd_q         <= 5'd0;
      alu_q        <= '0;
      rdata_q      <= '0;
      pc4_q        <= '0;
      instret_q    <= '0;
    end else begin
      valid_q      <= valid_d;
      reg_write_q  <= reg_write_d;
      result_src_q <= result_src_d;
      load_type_q  <= load_type_d;
      rd_q         <= rd_d;
      alu_q        <= alu_d;
      rdata_q      <= rdata_d;
      pc4_q        <= pc4_d;
      instret_q    <= instret_d;
    end
  end

  load_extend #(
    .XLEN(XLEN)
  ) u_load_extend (
    .read_data (rdata_q),
    .off       (alu_q[2:0]),
    .load_type (load_type_q),
    .ext_c     (load_val_c)
  );

  // Reserved source encoding yields zero.
  always_comb begin
    result_c = '0;
    case (result_src_q)
      RES_ALU:  result_c = alu_q;
      RES_LOAD: result_c = load_val_c;
      RES_PC4:  result_c = pc4_q;
      default:  result_c = '0;
    endcase
  end

  assign we_c = valid_q & reg_write_q & (rd_q != 5'd0);

  assign A3         = rd_q;
  assign WD3        = result_c;
  assign WE3        = we_c;
  assign Rd_W       = rd_q;
  assign RegWrite_W = we_c;
  assign Result_W   = result_c;
  assign instret    = instret_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed scoreboard bench for writeback_stage; a second instance with a
// 4-bit counter exercises instret wrap-around.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst, stall_W, flush_W, valid_M, RegWrite_M;
  logic [1:0]  ResultSrc_M;
  logic [2:0]  LoadType_M;
  logic [4:0]  Rd_M;
  logic [63:0] ALUResult_M, ReadData_M, PCPlus4_M;

  logic [4:0]  A3, Rd_W, A3_4, Rd_W_4;
  logic [63:0] WD3, Result_W, WD3_4, Result_W_4, instret;
  logic        WE3, RegWrite_W, WE3_4, RegWrite_W_4;
  logic [3:0]  instret_4;

  typedef struct packed {
    logic        we;
    logic [4:0]  a3;
    logic [63:0] wd;
    logic        cd;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [63:0] cnt_m  = '0;
  logic        vw_m   = 1'b0;

  localparam logic [63:0] RDATA = 64'h8877_6655_4433_2211;

  always #5 clk = ~clk;

  writeback_stage dut (
    .clk(clk), .rst(rst), .stall_W(stall_W), .flush_W(flush_W),
    .valid_M(valid_M), .RegWrite_M(RegWrite_M), .ResultSrc_M(ResultSrc_M),
    .LoadType_M(LoadType_M), .Rd_M(Rd_M), .ALUResult_M(ALUResult_M),
    .ReadData_M(ReadData_M), .PCPlus4_M(PCPlus4_M),
    .A3(A3), .WD3(WD3), .WE3(WE3), .Rd_W(Rd_W), .RegWrite_W(RegWrite_W),
    .Result_W(Result_W), .instret(instret)
  );

  writeback_stage #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .stall_W(stall_W), .flush_W(flush_W),
    .valid_M(valid_M), .RegWrite_M(RegWrite_M), .ResultSrc_M(ResultSrc_M),
    .LoadType_M(LoadType_M), .Rd_M(Rd_M), .ALUResult_M(ALUResult_M),
    .ReadData_M(ReadData_M), .PCPlus4_M(PCPlus4_M),
    .A3(A3_4), .WD3(WD3_4), .WE3(WE3_4), .Rd_W(Rd_W_4), .RegWrite_W(RegWrite_W_4),
    .Result_W(Result_W_4), .instret(instret_4)
  );

  task automatic step(input logic r, input logic st, input logic fl,
                      input logic v, input logic rw, input logic [1:0] src,
                      input logic [2:0] lt, input logic [4:0] rd,
                      input logic [63:0] alu, input logic [63:0] rdat,
                      input logic [63:0] pc, input logic ew,
                      input logic [4:0] ea, input logic [63:0] ed,
                      input logic cd, input string tag);
    exp_t e;
    rst = r; stall_W = st; flush_W = fl; valid_M = v; RegWrite_M = rw;
    ResultSrc_M = src; LoadType_M = lt; Rd_M = rd;
    ALUResult_M = alu; ReadData_M = rdat; PCPlus4_M = pc;
    sb.push_back('{we: ew, a3: ea, wd: ed, cd: cd});
    @(posedge clk);
    if (!r) begin
      cnt_m = '0; vw_m = 1'b0;
    end else if (fl) begin
      vw_m = 1'b0;
    end else if (!st) begin
      if (vw_m) cnt_m = cnt_m + 64'd1;
      vw_m = v;
    end
    #1;
    e = sb.pop_front();
    checks++;
    assert (WE3 === e.we) else begin
      errors++; $error("FAIL %s WE3 observed=%0b expected=%0b", tag, WE3, e.we);
    end
    checks++;
    assert (RegWrite_W === e.we) else begin
      errors++; $error("FAIL %s RegWrite_W observed=%0b expected=%0b", tag, RegWrite_W, e.we);
    end
    if (e.cd) begin
      checks++;
      assert (A3 === e.a3 && Rd_W === e.a3) else begin
        errors++; $error("FAIL %s A3/Rd_W observed=%0d/%0d expected=%0d", tag, A3, Rd_W, e.a3);
      end
      checks++;
      assert (WD3 === e.wd && Result_W === e.wd) else begin
        errors++; $error("FAIL %s WD3/Result_W observed=%h/%h expected=%h", tag, WD3, Result_W, e.wd);
      end
    end
    checks++;
    assert (instret === cnt_m) else begin
      errors++; $error("FAIL %s instret observed=%0d expected=%0d", tag, instret, cnt_m);
    end
    checks++;
    assert (instret_4 === cnt_m[3:0]) else begin
      errors++; $error("FAIL %s instret4 observed=%0d expected=%0d", tag, instret_4, cnt_m[3:0]);
    end
  endtask

  // Normal valid writing instruction, expected on the RF port next cycle.
  task automatic issue(input logic [1:0] src, input logic [2:0] lt,
                       input logic [4:0] rd, input logic [63:0] alu,
                       input logic [63:0] rdat, input logic [63:0] pc,
                       input logic ew, input logic [63:0] ed, input string tag);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, src, lt, rd, alu, rdat, pc, ew, rd, ed, 1'b1, tag);
  endtask

  initial begin
    rst = 1'b0; stall_W = 1'b0; flush_W = 1'b0; valid_M = 1'b0; RegWrite_M = 1'b0;
    ResultSrc_M = 2'b00; LoadType_M = 3'b000; Rd_M = 5'd0;
    ALUResult_M = '0; ReadData_M = '0; PCPlus4_M = '0;
    #2;

    step(0, 0, 0, 1, 1, 2'b00, 3'b000, 5'd5, 64'h5, 64'h0, 64'h0, 0, 5'd0, 64'h0, 1, "reset0");
    step(0, 0, 0, 1, 1, 2'b00, 3'b000, 5'd5, 64'h5, 64'h0, 64'h0, 0, 5'd0, 64'h0, 1, "reset1");

    issue(2'b00, 3'b000, 5'd7, 64'h1234, 64'h0, 64'h0, 1, 64'h1234, "alu_write");

    issue(2'b01, 3'b000, 5'd3, 64'd7, RDATA, 64'h0, 1, 64'hFFFF_FFFF_FFFF_FF88, "lb_off7");
    issue(2'b01, 3'b100, 5'd3, 64'd7, RDATA, 64'h0, 1, 64'h0000_0000_0000_0088, "lbu_off7");
    issue(2'b01, 3'b010, 5'd4, 64'd4, RDATA, 64'h0, 1, 64'hFFFF_FFFF_8877_6655, "lw_off4");
    issue(2'b01, 3'b110, 5'd4, 64'd4, RDATA, 64'h0, 1, 64'h0000_0000_8877_6655, "lwu_off4");
    issue(2'b01, 3'b011, 5'd4, 64'd0, RDATA, 64'h0, 1, RDATA, "ld_off0");
    issue(2'b01, 3'b001, 5'd5, 64'd6, RDATA, 64'h0, 1, 64'hFFFF_FFFF_FFFF_8877, "lh_off6");
    issue(2'b01, 3'b101, 5'd5, 64'd6, RDATA, 64'h0, 1, 64'h0000_0000_0000_8877, "lhu_off6");
    issue(2'b01, 3'b000, 5'd5, 64'd0, RDATA, 64'h0, 1, 64'h0000_0000_0000_0011, "lb_off0");
    issue(2'b01, 3'b111, 5'd5, 64'd0, RDATA, 64'h0, 1, 64'h0, "ld_type7");
    issue(2'b01, 3'b011, 5'd5, 64'd3, RDATA, 64'h0, 1, 64'h0000_0088_7766_5544, "ld_off3");
    issue(2'b10, 3'b000, 5'd6, 64'd99, RDATA, 64'h4004, 1, 64'h4004, "pc4");
    issue(2'b11, 3'b000, 5'd6, 64'd5, RDATA, 64'h4004, 1, 64'h0, "src_rsvd");

    issue(2'b00, 3'b000, 5'd0, 64'h55, 64'h0, 64'h0, 0, 64'h55, "x0_write");
    step(1, 0, 0, 1, 0, 2'b00, 3'b000, 5'd9, 64'h66, 64'h0, 64'h0, 0, 5'd9, 64'h66, 1, "no_regwrite");
    step(1, 1, 1, 1, 1, 2'b00, 3'b000, 5'd8, 64'h77, 64'h0, 64'h0, 0, 5'd0, 64'h0, 0, "flush_stall");
    issue(2'b00, 3'b000, 5'd8, 64'h88, 64'h0, 64'h0, 1, 64'h88, "after_flush");

    issue(2'b00, 3'b000, 5'd9, 64'hAAAA, 64'h0, 64'h0, 1, 64'hAAAA, "stall_load");
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 1, 1, 2'b00, 3'b000, 5'(10 + i), 64'(i), 64'h0, 64'h0,
           1, 5'd9, 64'hAAAA, 1, "stall_hold");
    end
    issue(2'b00, 3'b000, 5'd12, 64'hBBBB, 64'h0, 64'h0, 1, 64'hBBBB, "stall_release");

    step(0, 0, 0, 1, 1, 2'b00, 3'b000, 5'd1, 64'h1, 64'h0, 64'h0, 0, 5'd0, 64'h0, 1, "mid_reset");
    for (int i = 0; i < 18; i++) begin
      issue(2'b00, 3'b000, 5'd1, 64'(i), 64'h0, 64'h0, 1, 64'(i), "wrap_run");
    end
    checks++;
    assert (instret_4 === 4'd1) else begin
      errors++; $error("FAIL wrap instret4 observed=%0d expected=1", instret_4);
    end
    checks++;
    assert (instret === 64'd17) else begin
      errors++; $error("FAIL wrap instret observed=%0d expected=17", instret);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
